// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller with serial change return.
// Optional cancel/refund path enabled by defining VEND_CANCEL_EN.
module vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 5,
    parameter int COIN0    = 1,
    parameter int COIN1    = 2,
    parameter int COIN2    = 5,
    parameter int COIN3    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    localparam int MAX01    = COIN0 > COIN1 ? COIN0 : COIN1;
    localparam int MAX23    = COIN2 > COIN3 ? COIN2 : COIN3;
    localparam int MAX_COIN = MAX01 > MAX23 ? MAX01 : MAX23;
    localparam logic [CREDIT_W:0] C0      = (CREDIT_W+1)'(COIN0);
    localparam logic [CREDIT_W:0] C1      = (CREDIT_W+1)'(COIN1);
    localparam logic [CREDIT_W:0] C2      = (CREDIT_W+1)'(COIN2);
    localparam logic [CREDIT_W:0] C3      = (CREDIT_W+1)'(COIN3);
    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

    if (PRICE - 1 + MAX_COIN > (1 << CREDIT_W) - 1) begin : g_credit_w_chk
        $error("vend_ctrl: CREDIT_W too narrow for PRICE-1+max(COINn)");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, change_q, reject_q, busy_q, reject_d;
    logic [CREDIT_W:0]   coin_val, sum;
    logic                cancel_req;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_req    = 1'b0;
`endif

    assign coin_val = coin_sel == 2'd0 ? C0 :
                      coin_sel == 2'd1 ? C1 :
                      coin_sel == 2'd2 ? C2 : C3;
    assign sum      = {1'b0, credit_q} + coin_val;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            COLLECT: begin
                // a simultaneous cancel always refuses the coin, even with no credit to refund
                reject_d = coin_valid && cancel_req;
                if (cancel_req && credit_q != '0) begin
                    state_d = CHANGE;
                end else if (coin_valid && !cancel_req) begin
                    state_d  = sum >= PRICE_W ? VEND : COLLECT;
                    credit_d = sum >= PRICE_W ? CREDIT_W'(sum - PRICE_W) : CREDIT_W'(sum);
                end
            end
            VEND: begin
                reject_d = coin_valid;
                state_d  = credit_q != '0 ? CHANGE : COLLECT;
            end
            CHANGE: begin
                reject_d = coin_valid;
                credit_d = credit_q - CREDIT_W'(1);
                state_d  = credit_q == CREDIT_W'(1) ? COLLECT : CHANGE;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= state_d == VEND;
            change_q   <= state_d == CHANGE;
            reject_q   <= reject_d;
            busy_q     <= state_d != COLLECT;
        end
    end

    assign dispense     = dispense_q;
    assign change_pulse = change_q;
    assign coin_reject  = reject_q;
    assign busy         = busy_q;
    assign credit       = credit_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl with default parameters.
module tb_vend_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = 2'd0;
    logic       cancel = 1'b0;
    logic       dispense, change_pulse, coin_reject, busy;
    logic [4:0] credit;

    vend_ctrl dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .cancel(cancel), .dispense(dispense), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

`ifdef VEND_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    int n_vec = 0, n_err = 0;
    int n_disp, n_chg, n_rej, chg_credit_sum;
    int m_state = 0, m_credit = 0;
    bit m_rej = 1'b0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int coin_value(input logic [1:0] sel);
        return sel == 2'd0 ? 1 : sel == 2'd1 ? 2 : sel == 2'd2 ? 5 : 10;
    endfunction

    // reference model: state 0=COLLECT 1=VEND 2=CHANGE, advanced one clock per call
    task automatic model(input bit r, input bit cv, input logic [1:0] sel, input bit cn);
        bit can;
        int s;
        m_rej = 1'b0;
        can = CANCEL_EN && cn;
        if (r) begin
            m_state = 0;
            m_credit = 0;
        end else if (m_state == 0) begin
            m_rej = cv && can;
            if (can && m_credit > 0) m_state = 2;
            else if (cv && !can) begin
                s = m_credit + coin_value(sel);
                if (s >= 3) begin
                    m_credit = s - 3;
                    m_state = 1;
                end else m_credit = s;
            end
        end else if (m_state == 1) begin
            m_rej = cv;
            m_state = m_credit > 0 ? 2 : 0;
        end else begin
            m_rej = cv;
            m_credit--;
            if (m_credit == 0) m_state = 0;
        end
    endtask

    task automatic step(input bit r, input bit cv, input logic [1:0] sel, input bit cn);
        logic [8:0] got, exp;
        reset = r;
        coin_valid = cv;
        coin_sel = sel;
        cancel = cn;
        model(r, cv, sel, cn);
        exp_q.push_back({m_state == 1, m_state == 2, m_rej, m_state != 0, 5'(m_credit)});
        @(posedge clk);
        #1;
        got = {dispense, change_pulse, coin_reject, busy, credit};
        exp = exp_q.pop_front();
        chk("cycle", 32'(got), 32'(exp));
        n_disp += int'(dispense);
        n_chg += int'(change_pulse);
        n_rej += int'(coin_reject);
        if (change_pulse) chg_credit_sum += int'(credit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic coin(input logic [1:0] sel);
        step(1'b0, 1'b1, sel, 1'b0);
    endtask

    task automatic clr;
        n_disp = 0;
        n_chg = 0;
        n_rej = 0;
        chg_credit_sum = 0;
    endtask

    initial begin
        clr();
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("reset_out", {dispense, change_pulse, coin_reject, busy, credit}, 0);

        clr();
        coin(2'd0);
        coin(2'd1);
        chk("exact_disp_now", dispense, 1);
        idle(1);
        chk("exact_busy", busy, 0);
        idle(2);
        chk("exact_disp", n_disp, 1);
        chk("exact_chg", n_chg, 0);
        chk("exact_credit", credit, 0);

        clr();
        coin(2'd1);
        coin(2'd2);
        idle(7);
        chk("c25_disp", n_disp, 1);
        chk("c25_chg", n_chg, 4);
        chk("c25_credit_sum", chg_credit_sum, 10);

        clr();
        coin(2'd3);
        idle(10);
        chk("c10_disp", n_disp, 1);
        chk("c10_chg", n_chg, 7);
        chk("c10_busy", busy, 0);

        clr();
        coin(2'd1);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        idle(4);
        chk("cancel_disp", n_disp, 0);
        chk("cancel_chg", n_chg, CANCEL_EN ? 2 : 0);
        chk("cancel_credit", credit, CANCEL_EN ? 0 : 2);
        step(1'b1, 1'b0, 2'd0, 1'b0);

        clr();
        coin(2'd3);
        idle(2);
        coin(2'd0);
        chk("chg_reject", coin_reject, 1);
        coin(2'd0);
        chk("chg_reject_b2b", coin_reject, 1);
        idle(8);
        chk("chg_rej_count", n_rej, 2);
        chk("chg_rej_total", n_chg, 7);
        chk("chg_rej_sum", chg_credit_sum, 28);

        clr();
        coin(2'd0);
        step(1'b0, 1'b1, 2'd0, 1'b1);
        chk("cc_reject", coin_reject, CANCEL_EN ? 1 : 0);
        idle(4);
        chk("cc_chg", n_chg, CANCEL_EN ? 1 : 0);
        chk("cc_credit", credit, CANCEL_EN ? 0 : 2);
        step(1'b1, 1'b0, 2'd0, 1'b0);

        clr();
        coin(2'd3);
        idle(3);
        chk("rst_mid_pulses", n_chg, 3);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("rst_mid_out", {dispense, change_pulse, coin_reject, busy, credit}, 0);
        clr();
        coin(2'd0);
        coin(2'd1);
        idle(3);
        chk("post_rst_disp", n_disp, 1);
        chk("post_rst_chg", n_chg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
